dbus_arb: RTL and testbench

- Two-master arbiter for the shared SoC data port: address, read, write, strobe and write data toward the chip-select dispatch.
- Master 0 is the cpu load/store port; master 1 is a secondary bus master (DMA or debug loader).
- Fixed-priority is avoided: contention is resolved round-robin, with an optional bounded lock for bursts.
- Read data returns after a fixed memory latency and is routed back to the master that issued the read.

---
 rtl/dbus_arb.sv | 95 +++++++++
 tb/tb_dbus_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dbus_arb.sv
// dbus_arb: two-master round-robin data-port arbiter with bounded lock bursts and in-order read return routing.
module dbus_arb #(
  parameter int XLEN      = 32,
  parameter int WSW       = 4,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [WSW-1:0]  m0_wst,
  input  logic [XLEN-1:0] m0_adrs,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic            m0_lock,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [WSW-1:0]  m1_wst,
  input  logic [XLEN-1:0] m1_adrs,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            s_rd,
  output logic            s_we,
  output logic [WSW-1:0]  s_wst,
  output logic [XLEN-1:0] s_adrs,
  output logic [XLEN-1:0] s_wdata,
  input  logic [XLEN-1:0] s_rdata
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  logic            last, lock_v, lock_id;
  logic [BW-1:0]   bcnt;
  logic [XLEN-1:0] adrs_q, wdata_q;
  logic [RD_LAT-1:0] tv, to;
  logic hold, gany, gid, gwe, glock;
  // A lock holds only while its owner keeps req+lock asserted and the burst is below the cap;
  // once the cap is hit the owner was granted last, so round-robin hands the next tie to the other master.
  always_comb begin
    hold   = lock_v && (lock_id ? (m1_req && m1_lock) : (m0_req && m0_lock)) && (bcnt < BW'(MAX_BURST));
    m0_gnt = !rst && (hold ? !lock_id : (m0_req && (!m1_req || last)));
    m1_gnt = !rst && (hold ? lock_id : (m1_req && (!m0_req || !last)));
    gany   = m0_gnt || m1_gnt;
    gid    = m1_gnt;
    gwe    = gid ? m1_we : m0_we;
    glock  = gid ? m1_lock : m0_lock;
    s_rd   = gany && !gwe;
    s_we   = gany && gwe;
    s_wst  = !gany ? '0 : (gid ? m1_wst : m0_wst);
    s_adrs = !gany ? adrs_q : (gid ? m1_adrs : m0_adrs);
    s_wdata = !gany ? wdata_q : (gid ? m1_wdata : m0_wdata);
  end
  assign m0_rvalid = tv[RD_LAT-1] && !to[RD_LAT-1];
  assign m1_rvalid = tv[RD_LAT-1] && to[RD_LAT-1];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= 1'b1;
      lock_v  <= 1'b0;
      lock_id <= 1'b0;
      bcnt    <= '0;
      adrs_q  <= '0;
      wdata_q <= '0;
      tv      <= '0;
      to      <= '0;
    end else begin
      if (gany) begin
        last    <= gid;
        adrs_q  <= s_adrs;
        wdata_q <= s_wdata;
      end
      if (hold) begin
        bcnt <= bcnt + BW'(1);
      end else if (gany && glock) begin
        lock_v  <= 1'b1;
        lock_id <= gid;
        bcnt    <= BW'(1);
      end else begin
        lock_v <= 1'b0;
        bcnt   <= '0;
      end
      tv[0] <= s_rd;
      to[0] <= gid;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        tv[k] <= tv[k-1];
        to[k] <= to[k-1];
      end
    end
  end
endmodule

// File: tb/tb_dbus_arb.sv
// tb_dbus_arb: directed self-checking bench for dbus_arb (RD_LAT=2, MAX_BURST=8).
module tb_dbus_arb;
  logic        clk = 0, rst = 1;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_wst, m1_wst, s_wst;
  logic [31:0] m0_adrs, m0_wdata, m1_adrs, m1_wdata, s_adrs, s_wdata, s_rdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_rd, s_we;
  logic [31:0] m0_rdata, m1_rdata;
  int tests = 0, fails = 0;

  dbus_arb #(.XLEN(32), .WSW(4), .RD_LAT(2), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wst(m0_wst), .m0_adrs(m0_adrs), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wst(m1_wst), .m1_adrs(m1_adrs), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_rd(s_rd), .s_we(s_we), .s_wst(s_wst), .s_adrs(s_adrs), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_wst = 0; m0_adrs = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_wst = 0; m1_adrs = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); s_rdata = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); s_rdata = 32'h1234_5678;
    m0_req = 1; m0_adrs = 32'h10; m1_req = 1;
    tick(); #1;
    tests++; if ({m0_gnt, m1_gnt} !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    tests++; if ({s_rd, s_we, s_wst} !== 6'd0) begin fails++; $display("FAIL reset_strobes got %b exp 0", {s_rd, s_we, s_wst}); end
    tests++; if ({s_adrs, s_wdata} !== 64'd0) begin fails++; $display("FAIL reset_bus got %h exp 0", {s_adrs, s_wdata}); end
    tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_adrs = 32'h1000_0004; #1;
    tests++; if ({m0_gnt, m1_gnt, s_rd, s_we} !== 4'b1010) begin fails++; $display("FAIL rd_issue got %b exp 1010", {m0_gnt, m1_gnt, s_rd, s_we}); end
    tests++; if (s_adrs !== 32'h1000_0004) begin fails++; $display("FAIL rd_adrs got %h exp 10000004", s_adrs); end
    tick(); idle(); s_rdata = 32'h0; #1;
    tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL rd_early got %b exp 00", {m0_rvalid, m1_rvalid}); end
    tests++; if ({s_rd, s_adrs} !== {1'b0, 32'h1000_0004}) begin fails++; $display("FAIL idle_hold got %b/%h exp 0/10000004", s_rd, s_adrs); end
    tick(); s_rdata = 32'hDEAD_BEEF; #1;
    tests++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_return got %b/%h exp 10/deadbeef", {m0_rvalid, m1_rvalid}, m0_rdata); end
    tick(); #1;
    tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL rd_after got %b exp 00", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m0_adrs = 32'h100; m1_req = 1; m1_adrs = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || s_adrs !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin
        fails++; $display("FAIL alt[%0d] got %b/%h", i, {m0_gnt, m1_gnt}, s_adrs);
      end
      tick();
    end
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp;
    do_reset();
    m1_req = 1; m1_lock = 1; m1_adrs = 32'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = (i < 8 || i == 9) ? 2'b01 : 2'b10;
      tests++;
      if ({m0_gnt, m1_gnt} !== exp) begin fails++; $display("FAIL lock[%0d] got %b exp %b", i, {m0_gnt, m1_gnt}, exp); end
      tick();
      m0_req = 1; m0_adrs = 32'h100;
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) m0_lock = 0;
      #1;
      tests++;
      if ({m0_gnt, m1_gnt} !== ((i == 3) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL drop[%0d] got %b", i, {m0_gnt, m1_gnt}); end
      tick();
    end
  endtask

  task automatic test_interleave();
    do_reset();
    m0_req = 1; m0_adrs = 32'h3000_0000; #1;
    tests++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL il_g0 got %b exp 1", m0_gnt); end
    tick(); idle(); m1_req = 1; m1_adrs = 32'h4000_0004; #1;
    tests++; if (m1_gnt !== 1'b1 || s_adrs !== 32'h4000_0004) begin fails++; $display("FAIL il_g1 got %b/%h", m1_gnt, s_adrs); end
    tick(); idle();
    for (int c = 2; c < 6; c++) begin
      s_rdata = 32'hA000_0000 + c; #1;
      tests++;
      if ({m0_rvalid, m1_rvalid} !== ((c == 2) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00)) begin
        fails++; $display("FAIL il_rv[t+%0d] got %b", c, {m0_rvalid, m1_rvalid});
      end
      if (c == 3) begin
        tests++; if (m1_rdata !== 32'hA000_0003) begin fails++; $display("FAIL il_rdata got %h exp a0000003", m1_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_req = 1; m0_adrs = 32'h50; tick();
    m1_req = 1; #1;
    tests++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL ar_pre got %b exp 01", {m0_gnt, m1_gnt}); end
    #1 rst = 1; #1;
    tests++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_rd} !== 5'd0) begin fails++; $display("FAIL ar_drop got %b exp 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_rd}); end
    tick(); rst = 0; idle();
    for (int i = 0; i < 3; i++) begin
      s_rdata = 32'hFFFF_0000 + i; #1;
      tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL ar_post[%0d] got %b exp 00", i, {m0_rvalid, m1_rvalid}); end
      tick();
    end
  endtask

  task automatic test_write();
    do_reset();
    m1_req = 1; m1_we = 1; m1_wst = 4'b0011; m1_wdata = 32'hA5A5_1234; m1_adrs = 32'h2000; #1;
    tests++; if ({m1_gnt, m0_gnt, s_we, s_rd, s_wst} !== 8'b1010_0011) begin fails++; $display("FAIL wr_strobe got %b exp 10100011", {m1_gnt, m0_gnt, s_we, s_rd, s_wst}); end
    tests++; if (s_wdata !== 32'hA5A5_1234 || s_adrs !== 32'h2000) begin fails++; $display("FAIL wr_data got %h/%h", s_wdata, s_adrs); end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({m0_rvalid, m1_rvalid, s_we, s_wst} !== 7'd0 || s_wdata !== 32'hA5A5_1234) begin
        fails++; $display("FAIL wr_after[%0d] got %b/%h", i, {m0_rvalid, m1_rvalid, s_we, s_wst}, s_wdata);
      end
      tick();
    end
  endtask

  initial begin
    idle(); s_rdata = 0;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_lock_drop();
    test_interleave();
    test_async_reset();
    test_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
